// File: rtl/abp_pkg.sv
// abp_pkg: shared arbiter state, port indices and beat width for the ABP link
package abp_pkg;
  localparam int ACK_PORT = 0;
  localparam int DATA_PORT = 1;
  localparam int BEAT_W = 8;
  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_GRANT0 = 2'b01,
    ST_GRANT1 = 2'b10
  } arb_state_t;
  function automatic logic [1:0] grant_of(arb_state_t s);
    return s == ST_GRANT0 ? 2'b01 : s == ST_GRANT1 ? 2'b10 : 2'b00;
  endfunction
endpackage

// File: rtl/abp_stall_watchdog.sv
// abp_stall_watchdog: saturating count of idle beats on the owning stream, sticky error at the limit
module abp_stall_watchdog #(
  parameter int STALL_LIMIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_active,
  input  logic i_tvalid,
  output logic o_stall_err
);
  localparam int CW = $clog2(STALL_LIMIT + 1);
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic r_err;
  always_comb w_cnt_nxt = (!i_active || i_tvalid) ? '0 :
                          (r_cnt == CW'(STALL_LIMIT)) ? r_cnt : r_cnt + 1'b1;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      if (w_cnt_nxt == CW'(STALL_LIMIT)) r_err <= 1'b1;
    end
  assign o_stall_err = r_err;
endmodule

// File: rtl/abp_egress_arbiter.sv
// abp_egress_arbiter: packet-granular two-port AXI-Stream arbiter onto the shared ABP link
module abp_egress_arbiter
  import abp_pkg::*;
#(
  parameter int STALL_LIMIT = 16,
  parameter bit ACK_PRIORITY = 1'b1
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              s0_axis_tvalid,
  output logic              s0_axis_tready,
  input  logic              s0_axis_tlast,
  input  logic [BEAT_W-1:0] s0_axis_tdata,
  input  logic              s1_axis_tvalid,
  output logic              s1_axis_tready,
  input  logic              s1_axis_tlast,
  input  logic [BEAT_W-1:0] s1_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic [BEAT_W-1:0] m_axis_tdata,
  output logic [1:0]        grant,
  output logic              busy,
  output logic              stall_err,
  output logic [15:0]       pkt_cnt0,
  output logic [15:0]       pkt_cnt1
);
  arb_state_t r_state;
  logic r_armed, r_last;
  logic [15:0] r_cnt0, r_cnt1;
  logic w_g0, w_g1, w_gvalid, w_done, w_pick1;
  always_comb begin
    w_g0 = r_state == ST_GRANT0;
    w_g1 = r_state == ST_GRANT1;
    w_gvalid = w_g0 ? s0_axis_tvalid : w_g1 ? s1_axis_tvalid : 1'b0;
    m_axis_tvalid = w_gvalid;
    m_axis_tlast = w_g0 ? s0_axis_tlast : w_g1 ? s1_axis_tlast : 1'b0;
    m_axis_tdata = w_g0 ? s0_axis_tdata : w_g1 ? s1_axis_tdata : '0;
    s0_axis_tready = w_g0 & m_axis_tready;
    s1_axis_tready = w_g1 & m_axis_tready;
    w_done = w_gvalid & m_axis_tready & m_axis_tlast;
    // On a tie in round-robin mode the port that did not own the last packet wins
    w_pick1 = s1_axis_tvalid & (!s0_axis_tvalid | (!ACK_PRIORITY & !r_last));
  end
  // r_armed holds off arbitration for one edge after reset release
  always_ff @(posedge aclk or posedge areset)
    if (areset) begin
      r_state <= ST_IDLE;
      r_armed <= 1'b0;
      r_last <= 1'(DATA_PORT);
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else begin
      r_armed <= 1'b1;
      if (r_state == ST_IDLE) begin
        if (r_armed && (s0_axis_tvalid || s1_axis_tvalid))
          r_state <= w_pick1 ? ST_GRANT1 : ST_GRANT0;
      end else if (w_done) begin
        r_state <= ST_IDLE;
        r_last <= w_g1;
        if (w_g0) r_cnt0 <= r_cnt0 + 16'd1;
        else r_cnt1 <= r_cnt1 + 16'd1;
      end
    end
  abp_stall_watchdog #(.STALL_LIMIT(STALL_LIMIT)) u_wdog (
    .clk(aclk),
    .rst(areset),
    .i_active(w_g0 | w_g1),
    .i_tvalid(w_gvalid),
    .o_stall_err(stall_err)
  );
  assign grant = grant_of(r_state);
  assign busy = |grant;
  assign pkt_cnt0 = r_cnt0;
  assign pkt_cnt1 = r_cnt1;
endmodule

// File: tb/tb_abp_egress_arbiter.sv
// tb_abp_egress_arbiter: round-robin and ACK-priority instances driven by identical packet sources, scoreboarded egress
module tb_abp_egress_arbiter;
  logic clk = 1'b0;
  logic areset = 1'b1;
  logic m_ready = 1'b1;
  logic src_clr = 1'b1;
  logic sv[2][2], sr[2][2], sl[2][2];
  logic [7:0] sd[2][2];
  logic mv[2], ml[2], bz[2], se[2];
  logic [7:0] md[2];
  logic [1:0] gr[2];
  logic [15:0] c0[2], c1[2];
  logic hold[2];
  int npk[2], len[2];
  int pkt[2][2], beat[2][2];
  logic [10:0] q0[$], q1[$];
  logic [10:0] mon_got, mon_exp;
  logic prev_last[2];
  int n_run = 0, n_fail = 0;

  always #5 clk = ~clk;

  abp_egress_arbiter #(.STALL_LIMIT(16), .ACK_PRIORITY(1'b0)) u_rr (
    .aclk(clk), .areset(areset),
    .s0_axis_tvalid(sv[0][0]), .s0_axis_tready(sr[0][0]), .s0_axis_tlast(sl[0][0]), .s0_axis_tdata(sd[0][0]),
    .s1_axis_tvalid(sv[0][1]), .s1_axis_tready(sr[0][1]), .s1_axis_tlast(sl[0][1]), .s1_axis_tdata(sd[0][1]),
    .m_axis_tvalid(mv[0]), .m_axis_tready(m_ready), .m_axis_tlast(ml[0]), .m_axis_tdata(md[0]),
    .grant(gr[0]), .busy(bz[0]), .stall_err(se[0]), .pkt_cnt0(c0[0]), .pkt_cnt1(c1[0]));

  abp_egress_arbiter #(.STALL_LIMIT(16), .ACK_PRIORITY(1'b1)) u_pri (
    .aclk(clk), .areset(areset),
    .s0_axis_tvalid(sv[1][0]), .s0_axis_tready(sr[1][0]), .s0_axis_tlast(sl[1][0]), .s0_axis_tdata(sd[1][0]),
    .s1_axis_tvalid(sv[1][1]), .s1_axis_tready(sr[1][1]), .s1_axis_tlast(sl[1][1]), .s1_axis_tdata(sd[1][1]),
    .m_axis_tvalid(mv[1]), .m_axis_tready(m_ready), .m_axis_tlast(ml[1]), .m_axis_tdata(md[1]),
    .grant(gr[1]), .busy(bz[1]), .stall_err(se[1]), .pkt_cnt0(c0[1]), .pkt_cnt1(c1[1]));

  // Each DUT has its own copy of both sources; beat data encodes {port, packet lsb, beat index}
  always_comb
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < 2; p++) begin
        sv[d][p] = (pkt[d][p] < npk[p]) && !hold[p];
        sl[d][p] = beat[d][p] == len[p] - 1;
        sd[d][p] = {1'(p), 1'(pkt[d][p]), 6'(beat[d][p])};
      end

  always @(posedge clk)
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < 2; p++)
        if (src_clr) begin
          pkt[d][p] <= 0;
          beat[d][p] <= 0;
        end else if (sv[d][p] && sr[d][p]) begin
          if (sl[d][p]) begin
            beat[d][p] <= 0;
            pkt[d][p] <= pkt[d][p] + 1;
          end else beat[d][p] <= beat[d][p] + 1;
        end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk)
    if (areset) prev_last = '{1'b0, 1'b0};
    else
      for (int d = 0; d < 2; d++) begin
        if (prev_last[d]) chk($sformatf("bubble d%0d", d), 32'(gr[d]), 32'h0);
        prev_last[d] = mv[d] && m_ready && ml[d];
        if (mv[d] && m_ready) begin
          mon_got = {gr[d], ml[d], md[d]};
          if ((d == 0 ? q0.size() : q1.size()) == 0) begin
            n_run++;
            n_fail++;
            $display("FAIL unexpected beat d%0d: got %0h want none", d, mon_got);
          end else begin
            if (d == 0) mon_exp = q0.pop_front();
            else mon_exp = q1.pop_front();
            chk($sformatf("beat d%0d", d), 32'(mon_got), 32'(mon_exp));
          end
        end
      end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_pkt(int d, int p, int k);
    logic [10:0] v;
    for (int b = 0; b < len[p]; b++) begin
      v = {(p == 1) ? 2'b10 : 2'b01, (b == len[p] - 1) ? 1'b1 : 1'b0, 1'(p), 1'(k), 6'(b)};
      if (d == 0) q0.push_back(v);
      else q1.push_back(v);
    end
  endtask

  task automatic chk_reset(string tag);
    for (int d = 0; d < 2; d++) begin
      chk({tag, " grant"}, 32'(gr[d]), 0);
      chk({tag, " busy"}, 32'(bz[d]), 0);
      chk({tag, " treadys"}, 32'({sr[d][0], sr[d][1]}), 0);
      chk({tag, " m_valid/last"}, 32'({mv[d], ml[d]}), 0);
      chk({tag, " m_data"}, 32'(md[d]), 0);
      chk({tag, " stall_err"}, 32'(se[d]), 0);
      chk({tag, " pkt_cnts"}, {c0[d], c1[d]}, 0);
    end
  endtask

  task automatic start(int n0, int l0, int n1, int l1);
    areset = 1'b1;
    src_clr = 1'b1;
    hold = '{1'b0, 1'b0};
    m_ready = 1'b1;
    npk = '{n0, n1};
    len = '{l0, l1};
    q0.delete();
    q1.delete();
    tick;
    tick;
    src_clr = 1'b0;
    @(negedge clk);
    chk_reset("reset");
    tick;
    areset = 1'b0;
  endtask

  task automatic arb_latency(logic [1:0] g);
    tick;
    @(negedge clk);
    chk("grant edge1", 32'(gr[0]), 0);
    tick;
    @(negedge clk);
    chk("grant edge2", 32'(gr[0]), 32'(g));
    tick;
  endtask

  task automatic wait_pkts(int w0, int w1);
    for (int i = 0; i < 3000; i++) begin
      if (c0[0] == 16'(w0) && c1[0] == 16'(w1) && c0[1] == 16'(w0) && c1[1] == 16'(w1)) break;
      tick;
    end
    tick;
    tick;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("pkt_cnt0 d%0d", d), 32'(c0[d]), 32'(w0));
      chk($sformatf("pkt_cnt1 d%0d", d), 32'(c1[d]), 32'(w1));
      chk($sformatf("idle grant d%0d", d), 32'(gr[d]), 0);
    end
    chk("q0 drained", q0.size(), 0);
    chk("q1 drained", q1.size(), 0);
  endtask

  task automatic wait_beat(int p, int k, int b);
    for (int i = 0; i < 2000; i++) begin
      if (pkt[0][p] == k && beat[0][p] == b) break;
      tick;
    end
    chk("reach beat", 32'(pkt[0][p] == k && beat[0][p] == b), 1);
  endtask

  initial begin
    // Lone ACK packet of 64 beats
    start(1, 64, 0, 1);
    push_pkt(0, 0, 0);
    push_pkt(1, 0, 0);
    arb_latency(2'b01);
    wait_pkts(1, 0);
    // Simultaneous requests: round-robin alternates, ACK priority drains port 0 first
    start(3, 4, 3, 4);
    for (int k = 0; k < 3; k++) begin
      push_pkt(0, 0, k);
      push_pkt(0, 1, k);
    end
    for (int k = 0; k < 3; k++) push_pkt(1, 0, k);
    for (int k = 0; k < 3; k++) push_pkt(1, 1, k);
    wait_pkts(3, 3);
    // Granted port 1 goes quiet for more than the stall limit mid-packet
    start(0, 1, 1, 8);
    push_pkt(0, 1, 0);
    push_pkt(1, 1, 0);
    wait_beat(1, 0, 3);
    hold[1] = 1'b1;
    repeat (15) tick;
    @(negedge clk);
    for (int d = 0; d < 2; d++) chk($sformatf("stall 15 d%0d", d), 32'(se[d]), 0);
    tick;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("stall 16 d%0d", d), 32'(se[d]), 1);
      chk($sformatf("stall grant d%0d", d), 32'(gr[d]), 32'h2);
    end
    tick;
    hold[1] = 1'b0;
    wait_pkts(0, 1);
    for (int d = 0; d < 2; d++) chk($sformatf("stall sticky d%0d", d), 32'(se[d]), 1);
    // Long egress backpressure is not a stall
    start(1, 12, 0, 1);
    push_pkt(0, 0, 0);
    push_pkt(1, 0, 0);
    wait_beat(0, 0, 4);
    m_ready = 1'b0;
    repeat (40) tick;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("bp stall d%0d", d), 32'(se[d]), 0);
      chk($sformatf("bp valid d%0d", d), 32'(mv[d]), 1);
    end
    tick;
    m_ready = 1'b1;
    wait_pkts(1, 0);
    for (int d = 0; d < 2; d++) chk($sformatf("bp stall end d%0d", d), 32'(se[d]), 0);
    // Reset in the middle of a second packet clears everything at once
    start(2, 20, 0, 1);
    push_pkt(0, 0, 0);
    push_pkt(0, 0, 1);
    push_pkt(1, 0, 0);
    push_pkt(1, 0, 1);
    wait_beat(0, 1, 10);
    chk("cnt before reset", 32'(c0[0]), 1);
    areset = 1'b1;
    #1;
    chk_reset("async reset");
    q0.delete();
    q1.delete();
    src_clr = 1'b1;
    tick;
    src_clr = 1'b0;
    for (int d = 0; d < 2; d++) begin
      push_pkt(d, 0, 0);
      push_pkt(d, 0, 1);
    end
    areset = 1'b0;
    arb_latency(2'b01);
    wait_pkts(2, 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/abp_egress_arbiter.md
ABP_EGRESS_ARBITER -- requirements
Module: abp_egress_arbiter

Interface
REQ-001 Parameter STALL_LIMIT, default 16: consecutive granted-port tvalid-low cycles mid-packet before stall_err asserts.
REQ-002 Parameter ACK_PRIORITY, default 1: 1 = port 0 (ACK transmitter) wins simultaneous requests; 0 = round-robin.
REQ-003 Clocking: one clock, aclk; reset is asynchronous and active-high, port areset.
REQ-004 Port aclk  in  1  sole clock, all logic on rising edge.
REQ-005 Port areset  in  1  asynchronous, active-high reset.
REQ-006 Ports s0_axis_tvalid/tready/tlast/tdata  in/out/in/in  1/1/1/8  port 0, ACK transmitter stream.
REQ-007 Ports s1_axis_tvalid/tready/tlast/tdata  in/out/in/in  1/1/1/8  port 1, data transmitter stream.
REQ-008 Ports m_axis_tvalid/tready/tlast/tdata  out/in/out/out  1/1/1/8  shared link egress.
REQ-009 Port grant  out  2  one-hot current owner; 00 = none.
REQ-010 Port busy  out  1  high while any port owns the link.
REQ-011 Port stall_err  out  1  sticky stall flag.
REQ-012 Ports pkt_cnt0, pkt_cnt1  out  16  completed packets per port.

Function
REQ-013 State machine SHALL have states IDLE, GRANT0, GRANT1; arbitration is packet-granular, never mid-packet.
REQ-014 IDLE: all s*_tready = 0, m_axis_tvalid = 0; any s*_tvalid high -> selected GRANTx next cycle (1-cycle arbitration latency).
REQ-015 Selection, one requester: that port; both, ACK_PRIORITY=1: port 0; both, ACK_PRIORITY=0: port not granted last (last_grant resets to 1, so port 0 wins first tie).
REQ-016 GRANTx: m_axis_tvalid/tlast/tdata = sx_axis_tvalid/tlast/tdata combinationally; sx_axis_tready = m_axis_tready; other port's tready = 0.
REQ-017 GRANTx: handshake (tvalid & tready) with tlast=1 -> IDLE next cycle; last_grant <= x; pkt_cntx increments, wrapping 0xFFFF -> 0x0000.
REQ-018 Re-arbitration always passes through IDLE: min one bubble cycle between packets.
REQ-019 Non-granted port's tvalid held high SHALL NOT affect egress or counters.
REQ-020 Stall counter: in GRANTx, increments each cycle sx_axis_tvalid = 0, clears on any cycle sx_axis_tvalid = 1 and on IDLE entry; saturates at STALL_LIMIT.
REQ-021 Stall counter reaching STALL_LIMIT SHALL set stall_err, held until reset; grant retained, no packet abort.
REQ-022 m_axis_tready low with tvalid high (backpressure) SHALL NOT count as stall.
REQ-023 grant = 01 in GRANT0, 10 in GRANT1, 00 in IDLE; busy = |grant.
REQ-024 Single-beat packet (tvalid & tlast in first granted cycle, tready high) SHALL complete in one GRANT cycle.

Reset
REQ-025 areset asserted (any time, incl. mid-packet) SHALL immediately force: state IDLE, grant 00, busy 0, all tready 0, m_axis_tvalid/tlast 0, m_axis_tdata 0x00, stall_err 0, pkt_cnt0/1 0, stall counter 0, last_grant 1.
REQ-026 After areset deassertion, first grant SHALL occur no earlier than the second rising edge.

Structure
REQ-027 Package abp_pkg SHALL hold the arbiter state enum, port index constants (ACK_PORT=0, DATA_PORT=1), and the 8-bit beat width constant shared with the receiver transmitter.
REQ-028 One sub-module, abp_stall_watchdog (saturating counter + sticky flag, parameter STALL_LIMIT), instantiated once on the granted port's tvalid.

Verification
REQ-029 Only s0 sends 64-beat ACK packet, m_tready=1 -> grant 01 from cycle 2, 64 beats out in order, tlast on beat 64, pkt_cnt0=1, IDLE after.
REQ-030 s0 and s1 both valid same cycle, ACK_PRIORITY=0, three packets each -> egress order 0,1,0,1,0,1, one bubble between packets, pkt_cnt0=pkt_cnt1=3.
REQ-031 Same stimulus, ACK_PRIORITY=1, s0 always re-requesting -> all s0 packets first; s1 granted only when s0_tvalid low in IDLE.
REQ-032 Granted s1 drops tvalid 16 cycles mid-packet -> stall_err=1 on 16th cycle, grant stays 10, packet completes, stall_err stays 1.
REQ-033 m_tready held low 40 cycles mid-packet -> stall_err stays 0, no beats lost or duplicated.
REQ-034 areset pulsed at beat 10 of a granted packet -> outputs at reset values same cycle, pkt_cnt 0, fresh arbitration on second edge after release.
